// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter (bus master). Generates SCK/WS and shifts out one
// {left, right} frame per 2*DATA_WIDTH bit slots from a one-deep holding register.
module i2s_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] right_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sck_o,
  output logic                  ws_o,
  output logic                  sd_o,
  output logic                  underrun_o
);

  localparam int FW    = 2 * DATA_WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FW);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(FW - 1);
  localparam logic [BIT_W-1:0] WS_FIRST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] WS_LAST   = BIT_W'(FW - 2);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DIV_W-1:0]      r_div_cnt;
  logic                  r_sck;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [FW-1:0]         r_shift;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] r_right;
  logic                  r_ws;
  logic                  r_underrun;

  logic                  w_div_wrap;
  logic                  w_fall;
  logic                  w_frame_start;
  logic                  w_xfer;
  logic [BIT_W-1:0]      w_slot_next;
  logic [FW-1:0]         w_load;

  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_fall     = w_div_wrap && r_sck;
  assign w_xfer     = valid_i && !r_full;
  assign w_load     = r_full ? {r_left, r_right} : '0;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_slot_next   = r_bit_cnt;
    if (w_fall) begin
      if (r_state == IDLE || r_bit_cnt == SLOT_LAST) begin
        w_frame_start = 1'b1;
        w_slot_next   = '0;
      end else begin
        w_slot_next   = r_bit_cnt + 1'b1;
      end
      w_state_next = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div_cnt  <= '0;
      r_sck      <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_full     <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
      r_ws       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;

      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_sck     <= ~r_sck;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      // Slot, WS and data all advance together on the SCK falling edge.
      if (w_fall) begin
        r_bit_cnt <= w_slot_next;
        r_ws      <= (w_slot_next >= WS_FIRST) && (w_slot_next <= WS_LAST);
        if (w_frame_start) begin
          r_shift    <= w_load;
          r_underrun <= ~r_full;
        end else begin
          r_shift <= {r_shift[FW-2:0], 1'b0};
        end
      end

      // A full holder at frame start blocks any transfer on that edge (ready is low).
      if (w_frame_start && r_full) begin
        r_full <= 1'b0;
      end else if (w_xfer) begin
        r_full  <= 1'b1;
        r_left  <= left_i;
        r_right <= right_i;
      end
    end
  end

  assign ready_o    = ~r_full;
  assign sck_o      = r_sck;
  assign ws_o       = r_ws;
  assign sd_o       = r_shift[FW-1];
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: an edge-count/frame-level reference model
// predicts every output each cycle, and an SCK-rise receiver recovers whole frames.
module tb_i2s_transmitter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        sel   = 1'b0;   // 0: defaults DUT (16/4), 1: small DUT (8/1)
  logic        valid = 1'b0;
  logic [15:0] left  = '0;
  logic [15:0] right = '0;

  logic a_ready, a_sck, a_ws, a_sd, a_under;
  logic b_ready, b_sck, b_ws, b_sd, b_under;
  logic rst_a, rst_b;

  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  i2s_transmitter #(.DATA_WIDTH(16), .CLK_DIV(4)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .left_i(left), .right_i(right), .valid_i(valid),
    .ready_o(a_ready), .sck_o(a_sck), .ws_o(a_ws), .sd_o(a_sd), .underrun_o(a_under)
  );

  i2s_transmitter #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .left_i(left[7:0]), .right_i(right[7:0]), .valid_i(valid),
    .ready_o(b_ready), .sck_o(b_sck), .ws_o(b_ws), .sd_o(b_sd), .underrun_o(b_under)
  );

  logic o_ready, o_sck, o_ws, o_sd, o_under;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_sck   = sel ? b_sck   : a_sck;
  assign o_ws    = sel ? b_ws    : a_ws;
  assign o_sd    = sel ? b_sd    : a_sd;
  assign o_under = sel ? b_under : a_under;

  // Reference model state
  int          dw = 16;
  int          cd = 4;
  int          e;              // edges since reset release
  bit          armed = 1'b0;
  bit          hold_full;
  logic [31:0] hold_word;
  logic [31:0] frames[$];
  bit          under[$];
  bit          last_xfer;
  logic [31:0] rx;
  logic        prev_sck;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (edge %0d, dw %0d)", tag, got, exp, e, dw);
    end
  endtask

  function automatic logic [31:0] low_mask(input int w);
    logic [31:0] m;
    m = '1;
    if (w < 32) m = (32'd1 << w) - 32'd1;
    return m;
  endfunction

  task automatic compare_outputs();
    int          fp, n, k;
    logic [31:0] w;
    logic        sck_e, ws_e, sd_e, un_e;
    fp    = 4 * dw * cd;
    sck_e = ((e / cd) % 2) == 1;
    ws_e  = 1'b0;
    sd_e  = 1'b0;
    un_e  = 1'b0;
    n     = 0;
    k     = 0;
    w     = '0;
    if (e >= 2 * cd) begin
      n    = (e - 2 * cd) / fp;
      k    = ((e - 2 * cd) / (2 * cd)) % (2 * dw);
      w    = frames[n];
      ws_e = (k >= dw - 1) && (k <= 2 * dw - 2);
      sd_e = w[2 * dw - 1 - k];
      un_e = ((e - 2 * cd) % fp == 0) && under[n];
    end
    check("sck", o_sck, sck_e);
    check("ws", o_ws, ws_e);
    check("sd", o_sd, sd_e);
    check("underrun", o_under, un_e);
    check("ready", o_ready, !hold_full);
    // Receiver view: sample SD on each SCK rise, compare the whole frame at its end.
    if (e >= 2 * cd && prev_sck == 1'b0 && o_sck == 1'b1) begin
      if (k == 0) rx = '0;
      rx = {rx[30:0], o_sd};
      if (k == 2 * dw - 1) check("frame", rx & low_mask(2 * dw), w);
    end
    prev_sck = o_sck;
  endtask

  task automatic step(input bit r, input bit v, input logic [15:0] l, input logic [15:0] rr);
    bit          fs;
    bit          xfer;
    logic [31:0] m;
    @(negedge clk);
    if (armed) compare_outputs();
    rst   = r;
    valid = v;
    left  = l;
    right = rr;
    last_xfer = 1'b0;
    if (r) begin
      armed     = 1'b1;
      e         = 0;
      hold_full = 1'b0;
      hold_word = '0;
      frames.delete();
      under.delete();
      prev_sck  = 1'b0;
      rx        = '0;
    end else begin
      fs   = (e + 1 >= 2 * cd) && (((e + 1 - 2 * cd) % (4 * dw * cd)) == 0);
      xfer = v && !hold_full;
      if (fs) begin
        frames.push_back(hold_full ? hold_word : 32'd0);
        under.push_back(!hold_full);
        hold_full = 1'b0;
      end
      if (xfer) begin
        m         = low_mask(dw);
        hold_word = ((32'(l) & m) << dw) | (32'(rr) & m);
        hold_full = 1'b1;
      end
      last_xfer = xfer;
      e++;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(1'b0, ($urandom % 6) == 0, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    logic [15:0] cnt;

    // Defaults: reset, run into a frame, then reset again mid-frame for 3 cycles.
    sel = 1'b0; dw = 16; cd = 4; armed = 1'b0;
    do_reset(2);
    idle(100);
    do_reset(3);

    // Single frame ahead of the first fall, followed by underrun frames.
    idle(2);
    step(1'b0, 1'b1, 16'hA5C3, 16'h0F0F);
    idle(2 * 256 + 20);

    // Back-pressure: valid held high with an incrementing pair (n, ~n).
    do_reset(1);
    cnt = 16'h0100;
    for (int i = 0; i < 6 * 256; i++) begin
      step(1'b0, 1'b1, cnt, ~cnt);
      if (last_xfer) cnt = cnt + 16'd1;
    end

    // Collision: first transfer lands on the slot-0 fall edge (edge 2*CLK_DIV).
    do_reset(1);
    idle(2 * cd - 1);
    step(1'b0, 1'b1, 16'h1234, 16'h5678);
    idle(2 * 256 + 10);

    // Random traffic.
    do_reset(1);
    random_run(4 * 256);

    // Small parameter set: DATA_WIDTH=8, CLK_DIV=1.
    sel = 1'b1; dw = 8; cd = 1; armed = 1'b0;
    do_reset(2);
    step(1'b0, 1'b1, 16'h0081, 16'h007E);
    idle(100);
    random_run(300);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serialises parallel stereo samples into a standard (Philips) I2S stream. The block is the bus master: it generates the bit clock `sck_o` and word select `ws_o` from the system clock and drives `sd_o`. It is the transmit counterpart of the receive path, which resynchronises and edge-detects incoming SCK/WS/SD. Samples arrive through a one-deep valid/ready holding register; a frame with no sample available is sent as zeros and flagged.

## Interface
- `DATA_WIDTH`, default 16: bits per channel; legal values are 2 or more.
- `CLK_DIV`, default 4: `clk_i` cycles per SCK half-period; legal values are 1 or more.

- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `left_i`  in  DATA_WIDTH  left sample, two's complement, MSB first on the wire.
- `right_i`  in  DATA_WIDTH  right sample.
- `valid_i`  in  1  `left_i`/`right_i` are valid.
- `ready_o`  out  1  holding register is empty; a transfer occurs when `valid_i && ready_o`.
- `sck_o`  out  1  I2S bit clock, registered.
- `ws_o`  out  1  word select: 0 = left, 1 = right; registered.
- `sd_o`  out  1  serial data, registered; changes only on SCK falling edges.
- `underrun_o`  out  1  one-cycle pulse when a frame starts with the holding register empty.

## Operation
- **Reset values:** `sck_o`=0, `ws_o`=0, `sd_o`=0, `underrun_o`=0 and `ready_o`=1.
  - Internally, the divider counter, bit counter, shift register and holding-full flag are 0, and the state is IDLE.
  - Reset applies on the next `clk_i` edge at any point, including mid-frame. Held data is discarded.
- **Divider:**
  - The counter runs 0..CLK_DIV-1 continuously after reset.
  - When it reaches CLK_DIV-1, it wraps and `sck_o` toggles on that edge.
  - A toggle from 1 to 0 is a fall event. All slot logic advances only on fall events.
- **States:**
  - IDLE: from reset until the first fall event.
  - RUN: entered at the first fall event and kept until reset.
- **Bit slots:**
  - Each fall event in RUN begins slot k = 0..2*DATA_WIDTH-1. The bit counter wraps to 0 after 2*DATA_WIDTH-1.
  - The first fall event sets k=0.
- **Frame start:** on the fall event that begins slot 0:
  - If the holding register is full, the shift register loads {left, right} from the holding register and holding-full clears.
  - If the holding register is empty, the shift register loads all zeros and `underrun_o` pulses for exactly that one cycle.
- **Data output:**
  - `sd_o` during slot k equals shift register bit 2*DATA_WIDTH-1-k.
  - Left MSB is in slot 0, left LSB in slot DATA_WIDTH-1, right MSB in slot DATA_WIDTH, and right LSB in slot 2*DATA_WIDTH-1.
- **Word select:**
  - `ws_o` during slot k is 1 for k in DATA_WIDTH-1..2*DATA_WIDTH-2 and 0 otherwise.
  - WS therefore leads each channel's MSB by one SCK period.
  - `ws_o` and `sd_o` are 0 in IDLE.
- **Handshake:**
  - `ready_o` = NOT holding-full.
  - On a transfer, both samples are captured and holding-full sets on the next edge.
  - `valid_i` may be held high while `ready_o` is low; the data is not taken until `ready_o` is 1.
- **Simultaneous events:**
  - When the frame-start load and a transfer occur on the same edge, the load uses the pre-edge holding state.
  - This collision is only possible with holding empty, so that frame underruns and the new sample is kept for the next frame.
  - When holding is full at frame start, `ready_o` is 0 on that edge, so no transfer occurs. `ready_o` rises on the following cycle.

## Timing
- The SCK period is 2*CLK_DIV cycles with 50% duty.
  - After reset deassertion (counter 0 in the first cycle), the first `sck_o` rise is after edge CLK_DIV and the first fall is after edge 2*CLK_DIV.
- The frame period is 4*DATA_WIDTH*CLK_DIV cycles. With defaults this is 256 cycles.
- `sd_o` and `ws_o` update on the same edge as the SCK fall. They are stable for a full SCK period around each SCK rise, where the receiver samples.
- **Latency:** a sample accepted before the cycle of frame start k appears with its left MSB in slot 0 of that frame. Otherwise it appears in the next frame.
- **Throughput:** one sample pair per frame. `ready_o` is low from the edge after a transfer until the edge after the next frame start.

## Test plan
- **Reset values:** assert `rst_i` mid-frame for 3 cycles, release and hold `valid_i`=0.
  - During reset: all outputs at reset values, `ready_o`=1.
  - After release: first `sck_o` rise 4 cycles later and first fall 8 cycles later; period 8 thereafter (defaults).
- **Single frame:** `left_i`=16'hA5C3, `right_i`=16'h0F0F, one-cycle `valid_i` before the first fall.
  - A model sampling `sd_o`/`ws_o` on SCK rises recovers A5C3 with ws=0 and 0F0F with ws=1.
  - ws rises during left LSB (slot 15) and falls during right LSB (slot 31).
- **Underrun:** no samples sent.
  - `sd_o` stays 0 and the ws pattern is unchanged.
  - `underrun_o` is a single-cycle pulse every 256 cycles, aligned to each slot-0 fall.
- **Back-pressure:** `valid_i` held high continuously with an incrementing pair (n, ~n).
  - Exactly one transfer per frame.
  - Consecutive frames carry n, n+1, ... with no skips or repeats.
  - No underrun after the first frame.
- **Collision:** the first transfer coincides with the slot-0 fall edge.
  - That frame is zeros with `underrun_o`=1.
  - The next frame carries the sample.
- **Parameters:** DATA_WIDTH=8, CLK_DIV=1.
  - SCK period is 2 cycles and the frame is 32 cycles.
  - `left_i`=8'h81 and `right_i`=8'h7E are recovered bit-exact.
